// File: rtl/ps2_cmd_sequencer_if.sv
// ps2_cmd_sequencer_if: command handshake plus PS/2 transmitter/receiver signals of the sequencer
interface ps2_cmd_sequencer_if;
  logic       cmd_req;
  logic [7:0] cmd_byte;
  logic       has_arg;
  logic [7:0] arg_byte;
  logic       cmd_busy;
  logic       cmd_done;
  logic       cmd_error;
  logic [1:0] err_code;
  logic       w_enable;
  logic [7:0] data_in;
  logic       tx_finished;
  logic       tx_idle;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  modport master (
    input  cmd_req, cmd_byte, has_arg, arg_byte, tx_finished, tx_idle, rx_done_tick, rx_data,
    output cmd_busy, cmd_done, cmd_error, err_code, w_enable, data_in
  );
  modport slave (
    output cmd_req, cmd_byte, has_arg, arg_byte, tx_finished, tx_idle, rx_done_tick, rx_data,
    input  cmd_busy, cmd_done, cmd_error, err_code, w_enable, data_in
  );
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// ps2_cmd_sequencer: sends a PS/2 command (plus optional argument) and handles ACK/resend/error/timeout
module ps2_cmd_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 1_000_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TW          = 20
) (
  input logic                 clk,
  input logic                 reset,
  ps2_cmd_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_TX, WAIT_ACK, DONE, ERROR} state_t;
  state_t        state, state_d;
  logic          phase, phase_d, has_q, has_d, wen_q, wen_d;
  logic [1:0]    retry, retry_d, err_q, err_d;
  logic [TW-1:0] cnt, cnt_d;
  logic [7:0]    cmd_q, cmd_d, arg_q, arg_d, data_q, data_d;
  logic          timeout, can_retry, rx_ack, rx_resend, rx_err;
  assign timeout   = cnt >= TW'(ACK_TIMEOUT - 1);
  assign can_retry = retry < 2'(MAX_RETRY);
  assign rx_ack    = bus.rx_done_tick && bus.rx_data == 8'hFA;
  assign rx_resend = bus.rx_done_tick && bus.rx_data == 8'hFE;
  assign rx_err    = bus.rx_done_tick && bus.rx_data == 8'hFC;
  always_comb begin
    state_d = state;
    phase_d = phase;
    retry_d = retry;
    cnt_d   = cnt;
    cmd_d   = cmd_q;
    arg_d   = arg_q;
    has_d   = has_q;
    data_d  = data_q;
    err_d   = err_q;
    wen_d   = 1'b0;
    case (state)
      IDLE: if (bus.cmd_req) begin
        state_d = LOAD;
        phase_d = 1'b0;
        retry_d = 2'd0;
        cmd_d   = bus.cmd_byte;
        arg_d   = bus.arg_byte;
        has_d   = bus.has_arg;
      end
      LOAD: begin
        data_d  = phase ? arg_q : cmd_q;
        wen_d   = bus.tx_idle;
        state_d = bus.tx_idle ? WAIT_TX : LOAD;
      end
      WAIT_TX: if (bus.tx_finished) begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end
      WAIT_ACK: begin
        cnt_d = (cnt == '1) ? cnt : cnt + TW'(1);
        // a received byte takes precedence over a coincident timeout; unknown bytes fall through
        if (rx_ack) begin
          state_d = (!phase && has_q) ? LOAD : DONE;
          phase_d = phase | has_q;
          retry_d = (!phase && has_q) ? 2'd0 : retry;
        end else if (rx_err) begin
          state_d = ERROR;
          err_d   = 2'b01;
        end else if (rx_resend || timeout) begin
          state_d = can_retry ? LOAD : ERROR;
          retry_d = can_retry ? retry + 2'd1 : retry;
          err_d   = can_retry ? err_q : (rx_resend ? 2'b11 : 2'b10);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      phase  <= 1'b0;
      retry  <= 2'd0;
      cnt    <= '0;
      cmd_q  <= 8'h00;
      arg_q  <= 8'h00;
      has_q  <= 1'b0;
      data_q <= 8'h00;
      err_q  <= 2'b00;
      wen_q  <= 1'b0;
    end else begin
      state  <= state_d;
      phase  <= phase_d;
      retry  <= retry_d;
      cnt    <= cnt_d;
      cmd_q  <= cmd_d;
      arg_q  <= arg_d;
      has_q  <= has_d;
      data_q <= data_d;
      err_q  <= err_d;
      wen_q  <= wen_d;
    end
  end
  assign bus.cmd_busy  = state != IDLE;
  assign bus.cmd_done  = state == DONE;
  assign bus.cmd_error = state == ERROR;
  assign bus.err_code  = err_q;
  assign bus.w_enable  = wen_q;
  assign bus.data_in   = data_q;
endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// tb_ps2_cmd_sequencer: directed bench for the PS/2 command sequencer with ACK_TIMEOUT=200
module tb_ps2_cmd_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_seq = 1'b0;
  int total = 0, bad = 0, wen_cnt = 0, busy_gap = 0, w0 = 0;
  ps2_cmd_sequencer_if bus();
  ps2_cmd_sequencer #(.ACK_TIMEOUT(200), .MAX_RETRY(3), .TW(20)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.w_enable) wen_cnt++;
    if (in_seq && !bus.cmd_busy) busy_gap++;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [7:0] c, input logic h, input logic [7:0] a);
    bus.cmd_req = 1'b1; bus.cmd_byte = c; bus.has_arg = h; bus.arg_byte = a;
    tick;
    bus.cmd_req = 1'b0; bus.cmd_byte = ~c; bus.has_arg = ~h; bus.arg_byte = ~a;
    in_seq = 1'b1;
    chk("busy_after_accept", {31'd0, bus.cmd_busy}, 32'd1);
  endtask
  task automatic wait_wen(input string tag, input logic [7:0] exp, input int exp_lat, input int budget);
    int lat;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (bus.w_enable) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    if (lat >= 0) chk({tag, "_data"}, {24'd0, bus.data_in}, {24'd0, exp});
  endtask
  task automatic tx_fin(input logic [7:0] exp);
    repeat (3) tick;
    chk("data_hold", {24'd0, bus.data_in}, {24'd0, exp});
    bus.tx_finished = 1'b1;
    tick;
    bus.tx_finished = 1'b0;
  endtask
  task automatic reply(input logic [7:0] b);
    repeat (4) tick;
    bus.rx_data = b;
    bus.rx_done_tick = 1'b1;
    tick;
    bus.rx_done_tick = 1'b0;
  endtask
  task automatic finish_done(input string tag);
    chk({tag, "_done"}, {31'd0, bus.cmd_done}, 32'd1);
    chk({tag, "_noerr"}, {31'd0, bus.cmd_error}, 32'd0);
    in_seq = 1'b0;
    tick;
    chk({tag, "_done_pulse"}, {31'd0, bus.cmd_done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.cmd_busy}, 32'd0);
  endtask
  task automatic finish_err(input string tag, input logic [1:0] code);
    chk({tag, "_error"}, {31'd0, bus.cmd_error}, 32'd1);
    chk({tag, "_code"}, {30'd0, bus.err_code}, {30'd0, code});
    chk({tag, "_nodone"}, {31'd0, bus.cmd_done}, 32'd0);
    in_seq = 1'b0;
    tick;
    chk({tag, "_err_pulse"}, {31'd0, bus.cmd_error}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus.cmd_busy}, 32'd0);
  endtask
  initial begin
    int lat;
    bus.cmd_req = 1'b0; bus.cmd_byte = 8'h00; bus.has_arg = 1'b0; bus.arg_byte = 8'h00;
    bus.tx_finished = 1'b0; bus.tx_idle = 1'b1; bus.rx_done_tick = 1'b0; bus.rx_data = 8'h00;
    repeat (3) tick;
    chk("rst_busy", {31'd0, bus.cmd_busy}, 32'd0);
    chk("rst_wen", {31'd0, bus.w_enable}, 32'd0);
    chk("rst_data", {24'd0, bus.data_in}, 32'd0);
    chk("rst_err", {30'd0, bus.err_code}, 32'd0);
    reset = 1'b1;
    tick;
    // single command, plus a cmd_req while busy that must be dropped
    w0 = wen_cnt;
    start(8'hFF, 1'b0, 8'h00);
    wait_wen("t1_wen", 8'hFF, 0, 10);
    bus.cmd_req = 1'b1; bus.cmd_byte = 8'h55;
    tick;
    bus.cmd_req = 1'b0;
    tx_fin(8'hFF);
    reply(8'hFA);
    finish_done("t1");
    repeat (3) tick;
    chk("t1_no_requeue", {31'd0, bus.cmd_busy}, 32'd0);
    chk("t1_strobes", wen_cnt - w0, 32'd1);
    // command + argument, with a stray reply during WAIT_TX
    w0 = wen_cnt;
    start(8'hED, 1'b1, 8'h07);
    wait_wen("t2_cmd", 8'hED, 0, 10);
    reply(8'hFA);
    chk("t2_wait_tx_ignore", {31'd0, bus.cmd_done}, 32'd0);
    tx_fin(8'hED);
    reply(8'hFA);
    wait_wen("t2_arg", 8'h07, 0, 10);
    tx_fin(8'h07);
    reply(8'hFA);
    finish_done("t2");
    chk("t2_strobes", wen_cnt - w0, 32'd2);
    // two resends then ACK
    w0 = wen_cnt;
    start(8'hF4, 1'b0, 8'h00);
    wait_wen("t3_a", 8'hF4, 0, 10);
    tx_fin(8'hF4);
    reply(8'hFE);
    wait_wen("t3_b", 8'hF4, 0, 10);
    tx_fin(8'hF4);
    reply(8'hFE);
    wait_wen("t3_c", 8'hF4, 0, 10);
    tx_fin(8'hF4);
    reply(8'hFA);
    finish_done("t3");
    chk("t3_strobes", wen_cnt - w0, 32'd3);
    // no reply: three timeout retries, then timeout error
    w0 = wen_cnt;
    start(8'hF2, 1'b0, 8'h00);
    wait_wen("t4_first", 8'hF2, 0, 10);
    for (int r = 0; r < 3; r++) begin
      tx_fin(8'hF2);
      wait_wen("t4_retry", 8'hF2, 200, 300);
    end
    tx_fin(8'hF2);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (bus.cmd_error) begin
        lat = i;
        break;
      end
    end
    chk("t4_err_lat", lat, 32'd199);
    finish_err("t4", 2'b10);
    chk("t4_strobes", wen_cnt - w0, 32'd4);
    // unknown byte ignored, then device error
    start(8'hF3, 1'b0, 8'h00);
    wait_wen("t5_wen", 8'hF3, 0, 10);
    tx_fin(8'hF3);
    reply(8'h1C);
    chk("t5_ignore_busy", {31'd0, bus.cmd_busy}, 32'd1);
    chk("t5_ignore_err", {31'd0, bus.cmd_error}, 32'd0);
    reply(8'hFC);
    finish_err("t5", 2'b01);
    // resend limit: four 0xFE replies
    w0 = wen_cnt;
    start(8'hE6, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      wait_wen("t7_wen", 8'hE6, 0, 10);
      tx_fin(8'hE6);
      reply(8'hFE);
    end
    wait_wen("t7_last", 8'hE6, 0, 10);
    tx_fin(8'hE6);
    reply(8'hFE);
    finish_err("t7", 2'b11);
    chk("t7_strobes", wen_cnt - w0, 32'd4);
    // transmitter busy, then reset during WAIT_ACK
    bus.tx_idle = 1'b0;
    w0 = wen_cnt;
    start(8'hF5, 1'b0, 8'h00);
    repeat (50) tick;
    chk("t6_hold_wen", wen_cnt - w0, 32'd0);
    chk("t6_hold_busy", {31'd0, bus.cmd_busy}, 32'd1);
    bus.tx_idle = 1'b1;
    wait_wen("t6_wen", 8'hF5, 0, 10);
    tx_fin(8'hF5);
    repeat (10) tick;
    in_seq = 1'b0;
    w0 = wen_cnt;
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", {31'd0, bus.cmd_busy}, 32'd0);
    chk("t6_rst_done", {31'd0, bus.cmd_done}, 32'd0);
    chk("t6_rst_error", {31'd0, bus.cmd_error}, 32'd0);
    chk("t6_rst_code", {30'd0, bus.err_code}, 32'd0);
    chk("t6_rst_wen", {31'd0, bus.w_enable}, 32'd0);
    chk("t6_rst_data", {24'd0, bus.data_in}, 32'd0);
    repeat (3) tick;
    reset = 1'b1;
    repeat (3) tick;
    chk("t6_post_busy", {31'd0, bus.cmd_busy}, 32'd0);
    chk("t6_post_wen", wen_cnt - w0, 32'd0);
    start(8'hFF, 1'b0, 8'h00);
    wait_wen("t6_again", 8'hFF, 0, 10);
    tx_fin(8'hFF);
    reply(8'hFA);
    finish_done("t6");
    chk("busy_gap", busy_gap, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
